alu_sequencer: RTL and testbench

Fetch/execute controller that sequences the shared 8-bit ALU of the CPU core. It fetches 8-bit instructions from an external instruction source over a req/valid handshake and reads operands from an internal 4x8 register file. It drives the ALU's opcode, addrs and data inputs, then commits results, the carry/borrow flags, branch decisions and the toggle output. It sits between the chip IO (instruction stream, PC out) and the combinational ALU instance.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/seq_regfile.sv | 34 +++
 rtl/alu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU fetch/execute sequencer: opcodes,
// controller states and instruction field positions.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_MOV = 2'd3;

    // Instruction layout: [7:6] opcode, [5:2] addrs (rd = [5:4], rs = [3:2]).
    localparam int OPC_HI   = 7;
    localparam int OPC_LO   = 6;
    localparam int ADDRS_HI = 5;
    localparam int ADDRS_LO = 2;
    localparam int RD_HI    = 5;
    localparam int RD_LO    = 4;
    localparam int RS_HI    = 3;
    localparam int RS_LO    = 2;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2
    } state_t;

endpackage

// File: rtl/seq_regfile.sv
// Small register file for the sequencer: two asynchronous read ports,
// one synchronous write port, cleared synchronously by rst.
module seq_regfile #(
    parameter int NREGS = 4,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    output logic [7:0]        rdata0_o,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [7:0]        rdata1_o
);

    logic [7:0] mem_q [NREGS];

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

    // Clear every entry on reset; otherwise write one entry when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute/writeback controller driving an external combinational ALU.
// Holds the FSM, program counter, architectural flags and toggle pin.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int NREGS = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            instr_req,
    output logic [PC_W-1:0] pc,
    input  logic            instr_valid,
    input  logic [7:0]      instr_in,
    output logic [1:0]      alu_opcode,
    output logic [3:0]      alu_addrs,
    output logic [7:0]      alu_din0,
    output logic [7:0]      alu_din1,
    input  logic [7:0]      alu_dout,
    input  logic            alu_carry,
    input  logic            alu_borrow,
    input  logic            alu_bcf,
    input  logic            alu_bbf,
    input  logic            alu_buc,
    input  logic            alu_toggle,
    output logic            carry_flag,
    output logic            borrow_flag,
    output logic            toggle_pin,
    output logic            busy
);

    state_t          state_q, state_d;
    logic [7:0]      instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            carry_q, carry_d;
    logic            borrow_q, borrow_d;
    logic            toggle_q, toggle_d;

    // ALU outputs captured in EXEC and consumed in WB.
    logic [7:0]      aluRes_q, aluRes_d;
    logic            latCarry_q, latCarry_d;
    logic            latBorrow_q, latBorrow_d;
    logic            latBcf_q, latBcf_d;
    logic            latBbf_q, latBbf_d;
    logic            latBuc_q, latBuc_d;
    logic            latToggle_q, latToggle_d;

    logic [1:0]      opcode;
    logic [1:0]      rd;
    logic [1:0]      rs;
    logic [1:0]      raddr0;
    logic [7:0]      rdata0;
    logic [7:0]      rdata1;
    logic            regWe;
    logic [1:0]      regWaddr;
    logic            branchReq;
    logic            branchTaken;
    logic            unusedInstrBits;

    assign opcode = instr_q[OPC_HI:OPC_LO];
    assign rd     = instr_q[RD_HI:RD_LO];
    assign rs     = instr_q[RS_HI:RS_LO];
    assign raddr0 = (opcode == OP_MOV) ? rs : rd;
    assign unusedInstrBits = ^instr_q[1:0];

    assign alu_opcode  = opcode;
    assign alu_addrs   = instr_q[ADDRS_HI:ADDRS_LO];
    assign pc          = pc_q;
    assign carry_flag  = carry_q;
    assign borrow_flag = borrow_q;
    assign toggle_pin  = toggle_q;

    assign branchReq   = latBcf_q | latBbf_q | latBuc_q;
    assign branchTaken = (latBcf_q & carry_q) | (latBbf_q & borrow_q) | latBuc_q;

    seq_regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (regWe),
        .waddr_i (regWaddr),
        .wdata_i (aluRes_q),
        .raddr0_i(raddr0),
        .rdata0_o(rdata0),
        .raddr1_i(rs),
        .rdata1_o(rdata1)
    );

    // Next-state, ALU drive and commit decisions for the three-phase sequence.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        carry_d     = carry_q;
        borrow_d    = borrow_q;
        toggle_d    = toggle_q;
        aluRes_d    = aluRes_q;
        latCarry_d  = latCarry_q;
        latBorrow_d = latBorrow_q;
        latBcf_d    = latBcf_q;
        latBbf_d    = latBbf_q;
        latBuc_d    = latBuc_q;
        latToggle_d = latToggle_q;
        regWe       = 1'b0;
        regWaddr    = rd;
        instr_req   = 1'b0;
        busy        = 1'b0;
        alu_din0    = 8'h00;
        alu_din1    = 8'h00;

        case (state_q)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    instr_d = instr_in;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                busy        = 1'b1;
                alu_din0    = rdata0;
                alu_din1    = (opcode == OP_MOV) ? 8'h00 : rdata1;
                aluRes_d    = alu_dout;
                latCarry_d  = alu_carry;
                latBorrow_d = alu_borrow;
                latBcf_d    = alu_bcf;
                latBbf_d    = alu_bbf;
                latBuc_d    = alu_buc;
                latToggle_d = alu_toggle;
                state_d     = S_WB;
            end
            S_WB: begin
                busy = 1'b1;
                if (opcode != OP_MOV) begin
                    regWe    = 1'b1;
                    regWaddr = rd;
                    if (opcode == OP_ADD) carry_d  = latCarry_q;
                    if (opcode == OP_SUB) borrow_d = latBorrow_q;
                    pc_d = pc_q + PC_W'(1);
                end else if (!branchReq) begin
                    regWe    = 1'b1;
                    regWaddr = 2'd0;
                    pc_d     = pc_q + PC_W'(1);
                end else begin
                    pc_d = branchTaken ? PC_W'(aluRes_q) : pc_q + PC_W'(1);
                end
                toggle_d = toggle_q ^ latToggle_q;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and architectural registers; reset discards any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            instr_q     <= 8'h00;
            pc_q        <= '0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            toggle_q    <= 1'b0;
            aluRes_q    <= 8'h00;
            latCarry_q  <= 1'b0;
            latBorrow_q <= 1'b0;
            latBcf_q    <= 1'b0;
            latBbf_q    <= 1'b0;
            latBuc_q    <= 1'b0;
            latToggle_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            toggle_q    <= toggle_d;
            aluRes_q    <= aluRes_d;
            latCarry_q  <= latCarry_d;
            latBorrow_q <= latBorrow_d;
            latBcf_q    <= latBcf_d;
            latBbf_q    <= latBbf_d;
            latBuc_q    <= latBuc_d;
            latToggle_q <= latToggle_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU in the loop.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_req;
    logic [7:0] pc;
    logic       instr_valid;
    logic [7:0] instr_in;
    logic [1:0] alu_opcode;
    logic [3:0] alu_addrs;
    logic [7:0] alu_din0;
    logic [7:0] alu_din1;
    logic [7:0] aluDout;
    logic       aluCarry;
    logic       aluBorrow;
    logic       bcf, bbf, buc, tog;
    logic       carry_flag, borrow_flag, toggle_pin, busy;

    // Override for op 3 results so the bench can load constants and branch targets.
    logic       ovrEn;
    logic [7:0] ovrVal;

    int checks = 0;
    int passes = 0;
    logic [7:0] expPc;
    logic [7:0] d0, d1;

    alu_sequencer #(.PC_W(8), .NREGS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_req  (instr_req),
        .pc         (pc),
        .instr_valid(instr_valid),
        .instr_in   (instr_in),
        .alu_opcode (alu_opcode),
        .alu_addrs  (alu_addrs),
        .alu_din0   (alu_din0),
        .alu_din1   (alu_din1),
        .alu_dout   (aluDout),
        .alu_carry  (aluCarry),
        .alu_borrow (aluBorrow),
        .alu_bcf    (bcf),
        .alu_bbf    (bbf),
        .alu_buc    (buc),
        .alu_toggle (tog),
        .carry_flag (carry_flag),
        .borrow_flag(borrow_flag),
        .toggle_pin (toggle_pin),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared combinational ALU.
    always_comb begin
        aluDout   = 8'h00;
        aluCarry  = 1'b0;
        aluBorrow = 1'b0;
        case (alu_opcode)
            2'd0: {aluCarry, aluDout} = {1'b0, alu_din0} + {1'b0, alu_din1};
            2'd1: begin
                aluDout   = alu_din0 - alu_din1;
                aluBorrow = (alu_din0 < alu_din1);
            end
            2'd2: aluDout = alu_din0 ^ alu_din1;
            default: aluDout = ovrEn ? ovrVal : alu_din0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Issue one instruction; returns the ALU operands seen in EXEC.
    // Entered and left #1 after a rising edge.
    task automatic applyStimulus(input logic [7:0] ins, output logic [7:0] o0, output logic [7:0] o1);
        int waitCnt = 0;
        o0 = 8'h00;
        o1 = 8'h00;
        while (instr_req !== 1'b1 && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (instr_req !== 1'b1) begin
            checkOutput("fetch_timeout", {31'b0, instr_req}, 32'd1);
            return;
        end
        instr_in    = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr_in    = 8'h00;
        o0 = alu_din0;
        o1 = alu_din1;
        checkOutput("exec_busy", {31'b0, busy}, 32'd1);
        checkOutput("exec_req", {31'b0, instr_req}, 32'd0);
        @(posedge clk); #1;
        checkOutput("wb_busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        checkOutput("refetch_req", {31'b0, instr_req}, 32'd1);
        checkOutput("refetch_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic loadR0(input logic [7:0] val);
        logic [7:0] a, b;
        ovrEn  = 1'b1;
        ovrVal = val;
        applyStimulus(8'hC0, a, b);
        ovrEn  = 1'b0;
    endtask

    task automatic checkPc(input string tag);
        checkOutput(tag, {24'b0, pc}, {24'b0, expPc});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_in = 8'h00;
        bcf = 1'b0; bbf = 1'b0; buc = 1'b0; tog = 1'b0;
        ovrEn = 1'b0; ovrVal = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc", {24'b0, pc}, 32'h0);
        checkOutput("rst_req", {31'b0, instr_req}, 32'd1);
        checkOutput("rst_carry", {31'b0, carry_flag}, 32'd0);
        checkOutput("rst_borrow", {31'b0, borrow_flag}, 32'd0);
        checkOutput("rst_toggle", {31'b0, toggle_pin}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset while in EXEC: instruction that would load R0=0x55 is discarded.
        ovrEn = 1'b1; ovrVal = 8'h55;
        instr_in = 8'hC0; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checkOutput("midrst_in_exec", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_req", {31'b0, instr_req}, 32'd1);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_pc", {24'b0, pc}, 32'h0);
        @(posedge clk); #1;
        checkOutput("midrst_pc_hold", {24'b0, pc}, 32'h0);
        ovrEn = 1'b0;
        expPc = 8'h00;
        applyStimulus(8'hC0, d0, d1); expPc++;
        checkOutput("midrst_r0", {24'b0, d0}, 32'h00);
        checkOutput("mov_din1_zero", {24'b0, d1}, 32'h00);
        checkPc("pc_after_first");

        // Build R1=0xF0, R2=0x20 via R0, then add R1,R2.
        loadR0(8'hF0); expPc++;
        applyStimulus(8'h10, d0, d1); expPc++;
        loadR0(8'h20); expPc++;
        applyStimulus(8'h20, d0, d1); expPc++;
        applyStimulus(8'h18, d0, d1); expPc++;
        checkOutput("add_din0", {24'b0, d0}, 32'hF0);
        checkOutput("add_din1", {24'b0, d1}, 32'h20);
        checkOutput("add_carry", {31'b0, carry_flag}, 32'd1);
        checkPc("add_pc");
        applyStimulus(8'hC4, d0, d1); expPc++;
        checkOutput("add_r1", {24'b0, d0}, 32'h10);

        // R3=0x05, R0=0x07, sub R3,R0 -> 0xFE with borrow.
        loadR0(8'h05); expPc++;
        applyStimulus(8'h30, d0, d1); expPc++;
        checkOutput("add_nocarry", {31'b0, carry_flag}, 32'd0);
        loadR0(8'h07); expPc++;
        applyStimulus(8'h70, d0, d1); expPc++;
        checkOutput("sub_din0", {24'b0, d0}, 32'h05);
        checkOutput("sub_din1", {24'b0, d1}, 32'h07);
        checkOutput("sub_borrow", {31'b0, borrow_flag}, 32'd1);
        checkOutput("sub_carry_kept", {31'b0, carry_flag}, 32'd0);
        applyStimulus(8'hCC, d0, d1); expPc++;
        checkOutput("sub_r3", {24'b0, d0}, 32'hFE);

        // add R3,R3 sets carry and must not touch borrow.
        applyStimulus(8'h3C, d0, d1); expPc++;
        checkOutput("add2_carry", {31'b0, carry_flag}, 32'd1);
        checkOutput("add2_borrow_kept", {31'b0, borrow_flag}, 32'd1);

        // xor R2,R2 leaves both flags set.
        applyStimulus(8'hA8, d0, d1); expPc++;
        checkOutput("xor_din0", {24'b0, d0}, 32'h20);
        checkOutput("xor_carry_kept", {31'b0, carry_flag}, 32'd1);
        checkOutput("xor_borrow_kept", {31'b0, borrow_flag}, 32'd1);
        applyStimulus(8'hC8, d0, d1); expPc++;
        checkOutput("xor_r2", {24'b0, d0}, 32'h00);
        checkPc("pc_before_branch");

        // Taken bcf branch with carry=1.
        loadR0(8'h99); expPc++;
        bcf = 1'b1; ovrEn = 1'b1; ovrVal = 8'h40;
        applyStimulus(8'hC0, d0, d1);
        bcf = 1'b0; ovrEn = 1'b0;
        expPc = 8'h40;
        checkPc("bcf_taken_pc");
        applyStimulus(8'hC0, d0, d1); expPc++;
        checkOutput("bcf_taken_nowrite", {24'b0, d0}, 32'h99);

        // Clear carry, then the same bcf branch falls through.
        applyStimulus(8'h28, d0, d1); expPc++;
        checkOutput("clear_carry", {31'b0, carry_flag}, 32'd0);
        bcf = 1'b1; ovrEn = 1'b1; ovrVal = 8'h40;
        applyStimulus(8'hC4, d0, d1); expPc++;
        bcf = 1'b0; ovrEn = 1'b0;
        checkPc("bcf_not_taken_pc");
        applyStimulus(8'hC0, d0, d1); expPc++;
        checkOutput("bcf_not_taken_nowrite", {24'b0, d0}, 32'h99);

        // bcf+bbf together with carry=0, borrow=1: taken through borrow.
        bcf = 1'b1; bbf = 1'b1; ovrEn = 1'b1; ovrVal = 8'h80;
        applyStimulus(8'hC0, d0, d1);
        bcf = 1'b0; bbf = 1'b0;
        expPc = 8'h80;
        checkPc("bbf_taken_pc");

        // Unconditional branch to 0xFF, then wrap to 0.
        buc = 1'b1; ovrVal = 8'hFF;
        applyStimulus(8'hC0, d0, d1);
        buc = 1'b0; ovrEn = 1'b0;
        expPc = 8'hFF;
        checkPc("buc_pc");
        applyStimulus(8'hC0, d0, d1); expPc++;
        checkPc("pc_wrap");

        // Toggle twice.
        tog = 1'b1;
        applyStimulus(8'hC0, d0, d1); expPc++;
        checkOutput("toggle_first", {31'b0, toggle_pin}, 32'd1);
        applyStimulus(8'hC0, d0, d1); expPc++;
        checkOutput("toggle_second", {31'b0, toggle_pin}, 32'd0);
        tog = 1'b0;

        // Stalled fetch: valid held low for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_req", {31'b0, instr_req}, 32'd1);
            checkOutput("stall_busy", {31'b0, busy}, 32'd0);
            checkPc("stall_pc");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
